hdb3_rx_checker: RTL and testbench

- Receive-end companion to the HDB3 encoder. Consumes the bipolar line pair (hdb3_p/hdb3_n), one symbol per sys_clk.
- Reconstructs the NRZ data stream by removing 000V/B00V substitutions.
- Detects line-code violations, keeps saturating error counters and runs a lock/loss state machine.
- Sits after the encoder in the loopback top or at a board receive pin; gives link-quality status the plain decoder does not provide.

---
 rtl/hdb3_pkg.sv | 34 +++
 rtl/hdb3_lock_fsm.sv | 77 +++++++
 rtl/hdb3_rx_checker.sv | 136 +++++++++++++
 tb/tb_hdb3_rx_checker.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdb3_pkg.sv
// HDB3 receive checker shared definitions.
// Symbol codes {p,n}, mark polarity, error-type bit indices, lock states.
package hdb3_pkg;

    localparam logic [1:0] SYM_ZERO = 2'b00;
    localparam logic [1:0] SYM_NEG  = 2'b01;
    localparam logic [1:0] SYM_POS  = 2'b10;
    localparam logic [1:0] SYM_ILL  = 2'b11;

    typedef enum logic [1:0] {
        POL_NONE = 2'b00,
        POL_POS  = 2'b01,
        POL_NEG  = 2'b10
    } pol_e;

    localparam int ERR_BPV   = 0;
    localparam int ERR_ZEROS = 1;
    localparam int ERR_BOTH  = 2;

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_st_e;

    // Illegal and zero symbols carry no polarity.
    function automatic pol_e sym_pol(input logic [1:0] sym);
        pol_e pol;
        pol = POL_NONE;
        if (sym == SYM_POS) pol = POL_POS;
        if (sym == SYM_NEG) pol = POL_NEG;
        return pol;
    endfunction

endpackage

// File: rtl/hdb3_lock_fsm.sv
// HDB3 link lock/loss machine: HUNT until LOCK_N clean symbols, then
// LOCKED until LOSS_N errored symbols occur with no LOCK_N clean run between.
// Ports: sys_clk, rst_n, sym_strobe (symbol processed), sym_err, locked.
module hdb3_lock_fsm
    import hdb3_pkg::*;
#(
    parameter int LOCK_N = 32,
    parameter int LOSS_N = 4
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic sym_strobe,
    input  logic sym_err,
    output logic locked
);

    localparam int CW = $clog2(LOCK_N + 1);
    localparam int LW = $clog2(LOSS_N + 1);
    localparam logic [CW-1:0] C_RUN_LAST  = CW'(LOCK_N - 1);
    localparam logic [LW-1:0] C_LOSS_LAST = LW'(LOSS_N - 1);

    lock_st_e        r_state, w_state_nx;
    logic [CW-1:0]   r_run,   w_run_nx;
    logic [LW-1:0]   r_loss,  w_loss_nx;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_HUNT;
            r_run   <= '0;
            r_loss  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_run   <= w_run_nx;
            r_loss  <= w_loss_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_run_nx   = r_run;
        w_loss_nx  = r_loss;
        if (sym_strobe) begin
            unique case (r_state)
                ST_HUNT: begin
                    if (sym_err) begin
                        w_run_nx = '0;
                    end else if (r_run == C_RUN_LAST) begin
                        w_run_nx   = '0;
                        w_state_nx = ST_LOCKED;
                    end else begin
                        w_run_nx = r_run + 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (sym_err) begin
                        w_run_nx = '0;
                        if (r_loss == C_LOSS_LAST) begin
                            w_loss_nx  = '0;
                            w_state_nx = ST_HUNT;
                        end else begin
                            w_loss_nx = r_loss + 1'b1;
                        end
                    end else if (r_run == C_RUN_LAST) begin
                        // a full clean run forgives earlier errors
                        w_run_nx  = '0;
                        w_loss_nx = '0;
                    end else begin
                        w_run_nx = r_run + 1'b1;
                    end
                end
            endcase
        end
    end

    assign locked = (r_state == ST_LOCKED);

endmodule

// File: rtl/hdb3_rx_checker.sv
// HDB3 receive checker: decodes the bipolar pair to NRZ (latency 4),
// flags bpv/zeros/illegal symbols, keeps saturating counters, reports lock.
// Ports: sys_clk, rst_n, hdb3_p/n, clr_cnt -> data_out, data_valid,
// err_pulse, err_type {both,zeros,bpv}, err_cnt, sym_cnt, locked.
module hdb3_rx_checker
    import hdb3_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int LOCK_N = 32,
    parameter int LOSS_N = 4
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic             hdb3_p,
    input  logic             hdb3_n,
    input  logic             clr_cnt,
    output logic             data_out,
    output logic             data_valid,
    output logic             err_pulse,
    output logic [2:0]       err_type,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] sym_cnt,
    output logic             locked
);

    logic [1:0]       r_sym;
    logic             r_sym_v;
    pol_e             r_last_mark;
    pol_e             r_last_v;
    logic [1:0]       r_zrun;
    logic [3:0]       r_dl_bit;
    logic [3:0]       r_dl_v;
    pol_e             r_dl_pol [3];
    logic             r_err_pulse;
    logic [2:0]       r_err_type;
    logic [CNT_W-1:0] r_err_cnt;
    logic [CNT_W-1:0] r_sym_cnt;

    pol_e       w_pol;
    logic       w_ill;
    logic       w_zero;
    logic       w_is_v;
    logic       w_v_ok;
    logic       w_v_sub;
    logic       w_bit;
    logic       w_err;
    logic [2:0] w_type;

    // Illegal symbols behave as zeros everywhere except err_type.
    assign w_pol  = sym_pol(r_sym);
    assign w_ill  = (r_sym == SYM_ILL);
    assign w_zero = (r_sym == SYM_ZERO) || w_ill;
    assign w_is_v = (w_pol != POL_NONE) && (w_pol == r_last_mark);

    // Delay-line polarities are the raw line symbols, not decoded bits.
    assign w_v_ok = (r_dl_pol[0] == POL_NONE) &&
                    (r_dl_pol[1] == POL_NONE) &&
                    ((r_dl_pol[2] == POL_NONE) ||
                     (r_dl_pol[2] == w_pol));

    assign w_v_sub = r_sym_v && w_is_v && w_v_ok;
    assign w_bit   = r_sym_v && !w_zero && !w_v_sub;

    always_comb begin
        w_type = '0;
        w_type[ERR_BOTH]  = w_ill;
        w_type[ERR_ZEROS] = w_zero && (r_zrun == 2'd3);
        w_type[ERR_BPV]   = w_is_v &&
                            (!w_v_ok || (r_last_v == w_pol));
    end

    assign w_err = r_sym_v && (|w_type);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sym       <= SYM_ZERO;
            r_sym_v     <= 1'b0;
            r_last_mark <= POL_NONE;
            r_last_v    <= POL_NONE;
            r_zrun      <= '0;
            r_dl_bit    <= '0;
            r_dl_v      <= '0;
            r_dl_pol    <= '{default: POL_NONE};
            r_err_pulse <= 1'b0;
            r_err_type  <= '0;
            r_err_cnt   <= '0;
            r_sym_cnt   <= '0;
        end else begin
            r_sym   <= {hdb3_p, hdb3_n};
            r_sym_v <= 1'b1;
            // a substitution zeroes the V and its three predecessors
            r_dl_bit <= {r_dl_bit[2:0] & {3{~w_v_sub}}, w_bit};
            r_dl_v   <= {r_dl_v[2:0], r_sym_v};
            r_dl_pol[0] <= r_sym_v ? w_pol : POL_NONE;
            r_dl_pol[1] <= r_dl_pol[0];
            r_dl_pol[2] <= r_dl_pol[1];
            if (r_sym_v) begin
                if (w_pol != POL_NONE) r_last_mark <= w_pol;
                if (w_is_v)            r_last_v    <= w_pol;
                if (!w_zero)
                    r_zrun <= '0;
                else if (r_zrun != 2'd3)
                    r_zrun <= r_zrun + 2'd1;
            end
            r_err_pulse <= w_err;
            r_err_type  <= r_sym_v ? w_type : 3'b000;
            if (clr_cnt)
                r_err_cnt <= '0;
            else if (w_err && (r_err_cnt != '1))
                r_err_cnt <= r_err_cnt + 1'b1;
            if (clr_cnt)
                r_sym_cnt <= '0;
            else if (r_sym_v && (r_sym_cnt != '1))
                r_sym_cnt <= r_sym_cnt + 1'b1;
        end
    end

    hdb3_lock_fsm #(
        .LOCK_N (LOCK_N),
        .LOSS_N (LOSS_N)
    ) u_lock (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .sym_strobe (r_sym_v),
        .sym_err    (w_err),
        .locked     (locked)
    );

    assign data_out   = r_dl_bit[3];
    assign data_valid = r_dl_v[3];
    assign err_pulse  = r_err_pulse;
    assign err_type   = r_err_type;
    assign err_cnt    = r_err_cnt;
    assign sym_cnt    = r_sym_cnt;

endmodule

// File: tb/tb_hdb3_rx_checker.sv
// Bench for hdb3_rx_checker: directed and random HDB3 streams
// checked against a stream-level reference model.
module tb_hdb3_rx_checker;

    localparam int CNT_W  = 6;
    localparam int LOCK_N = 32;
    localparam int LOSS_N = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;
    localparam int MAXN   = 160;
    localparam int ILL    = 2;

    logic             sys_clk;
    logic             rst_n;
    logic             hdb3_p;
    logic             hdb3_n;
    logic             clr_cnt;
    logic             data_out;
    logic             data_valid;
    logic             err_pulse;
    logic [2:0]       err_type;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] sym_cnt;
    logic             locked;

    hdb3_rx_checker #(
        .CNT_W  (CNT_W),
        .LOCK_N (LOCK_N),
        .LOSS_N (LOSS_N)
    ) dut (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .hdb3_p     (hdb3_p),
        .hdb3_n     (hdb3_n),
        .clr_cnt    (clr_cnt),
        .data_out   (data_out),
        .data_valid (data_valid),
        .err_pulse  (err_pulse),
        .err_type   (err_type),
        .err_cnt    (err_cnt),
        .sym_cnt    (sym_cnt),
        .locked     (locked)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_vec = 0;
    int n_err = 0;

    int   n;
    int   s     [MAXN];
    bit   clr_a [MAXN];
    bit   m_bit [MAXN];
    int   m_et  [MAXN];
    int   m_ec  [MAXN];
    int   m_sc  [MAXN];
    bit   m_lk  [MAXN];
    bit   o_bit [MAXN];
    bit   o_ep  [MAXN];
    int   o_et  [MAXN];
    int   o_ec  [MAXN];
    int   o_sc  [MAXN];
    bit   o_lk  [MAXN];

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    function automatic int lv(input int i);
        if (i < 0) return 0;
        return (s[i] == ILL) ? 0 : s[i];
    endfunction

    function automatic logic [1:0] enc(input int v);
        if (v == ILL) return 2'b11;
        if (v == 1)   return 2'b10;
        if (v == -1)  return 2'b01;
        return 2'b00;
    endfunction

    task automatic clear_stream(input int len);
        n = len;
        for (int i = 0; i < MAXN; i++) begin
            s[i] = 0;
            clr_a[i] = 1'b0;
        end
    endtask

    // Reference HDB3 encoder producing clean line symbols.
    task automatic gen_hdb3(input int len);
        int pol, par, zc;
        pol = -1; par = 0; zc = 0;
        for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                pol = -pol; s[i] = pol; par ^= 1; zc = 0;
            end else begin
                s[i] = 0; zc++;
                if (zc == 4) begin
                    if (par == 0) begin
                        pol = -pol; s[i-3] = pol;
                    end
                    s[i] = pol; par = 0; zc = 0;
                end
            end
        end
    endtask

    task automatic model();
        int lastm, lastv, zrun, run, loss, val, t, ec, sc;
        bit lk, ok;
        lastm = 0; lastv = 0; zrun = 0; run = 0; loss = 0; lk = 0;
        for (int j = 0; j < n; j++) begin
            val = lv(j);
            m_bit[j] = (val != 0);
            t = 0;
            if (s[j] == ILL) t += 4;
            zrun = (val == 0) ? zrun + 1 : 0;
            if (zrun >= 4) t += 2;
            if (val != 0) begin
                if (lastm == val) begin
                    ok = (lv(j-1) == 0) && (lv(j-2) == 0) &&
                         ((lv(j-3) == 0) || (lv(j-3) == val));
                    if (!ok || lastv == val) t += 1;
                    if (ok)
                        for (int k = j - 3; k <= j; k++)
                            if (k >= 0) m_bit[k] = 1'b0;
                    lastv = val;
                end
                lastm = val;
            end
            m_et[j] = t;
            if (!lk) begin
                if (t != 0) run = 0;
                else begin
                    run++;
                    if (run == LOCK_N) begin lk = 1; run = 0; end
                end
            end else begin
                if (t != 0) begin
                    run = 0; loss++;
                    if (loss == LOSS_N) begin lk = 0; loss = 0; end
                end else begin
                    run++;
                    if (run == LOCK_N) begin run = 0; loss = 0; end
                end
            end
            m_lk[j] = lk;
        end
        ec = 0; sc = 0;
        for (int e = 0; e < n; e++) begin
            if (e >= 1) begin
                if (m_et[e-1] != 0 && ec < CMAX) ec++;
                if (sc < CMAX) sc++;
            end
            if (clr_a[e]) begin ec = 0; sc = 0; end
            m_ec[e] = ec;
            m_sc[e] = sc;
        end
    endtask

    task automatic run_stream();
        model();
        rst_n = 1'b0;
        {hdb3_p, hdb3_n} = 2'b00;
        clr_cnt = 1'b0;
        @(posedge sys_clk); #1;
        chk("rst_dout",  int'(data_out),   0);
        chk("rst_valid", int'(data_valid), 0);
        chk("rst_epulse", int'(err_pulse), 0);
        chk("rst_etype", int'(err_type),   0);
        chk("rst_ecnt",  int'(err_cnt),    0);
        chk("rst_scnt",  int'(sym_cnt),    0);
        chk("rst_lock",  int'(locked),     0);
        @(negedge sys_clk);
        rst_n = 1'b1;
        for (int e = 0; e < n; e++) begin
            {hdb3_p, hdb3_n} = enc(s[e]);
            clr_cnt = clr_a[e];
            @(posedge sys_clk); #1;
            o_ec[e] = int'(err_cnt);
            o_sc[e] = int'(sym_cnt);
            chk("err_cnt", o_ec[e], m_ec[e]);
            chk("sym_cnt", o_sc[e], m_sc[e]);
            if (e >= 1) begin
                o_ep[e-1] = err_pulse;
                o_et[e-1] = int'(err_type);
                o_lk[e-1] = locked;
                chk("err_pulse", int'(err_pulse), int'(m_et[e-1] != 0));
                chk("err_type",  o_et[e-1], m_et[e-1]);
                chk("locked",    int'(locked), int'(m_lk[e-1]));
            end
            if (e >= 4) begin
                o_bit[e-4] = data_out;
                chk("data_out",   int'(data_out), int'(m_bit[e-4]));
                chk("data_valid", int'(data_valid), 1);
            end else begin
                chk("data_valid", int'(data_valid), 0);
            end
            @(negedge sys_clk);
        end
        clr_cnt = 1'b0;
    endtask

    initial begin
        int rate, r;
        rst_n = 1'b0;
        hdb3_p = 1'b0;
        hdb3_n = 1'b0;
        clr_cnt = 1'b0;

        // 000V after a mark
        clear_stream(9);
        s[0] = 1; s[4] = 1;
        run_stream();
        for (int j = 0; j < 5; j++) begin
            chk("v000_bit", int'(o_bit[j]), (j == 0) ? 1 : 0);
            chk("v000_ep",  int'(o_ep[j]), 0);
        end

        // B00V
        clear_stream(9);
        s[0] = 1; s[1] = -1; s[4] = -1;
        run_stream();
        for (int j = 0; j < 5; j++) begin
            chk("b00v_bit", int'(o_bit[j]), (j == 0) ? 1 : 0);
            chk("b00v_ep",  int'(o_ep[j]), 0);
        end

        // illegal symbol
        clear_stream(8);
        s[0] = 1; s[1] = ILL; s[2] = -1; s[3] = 1;
        run_stream();
        chk("ill_type", o_et[1], 4);
        chk("ill_cnt",  o_ec[2], 1);
        chk("ill_bit",  int'(o_bit[1]), 0);

        // five zeros after a mark
        clear_stream(11);
        s[0] = 1; s[6] = -1;
        run_stream();
        chk("z3_type", o_et[3], 0);
        chk("z4_type", o_et[4], 2);
        chk("z5_type", o_et[5], 2);
        chk("z_cnt",   o_ec[7], 2);

        // lock after 32 clean symbols, loss after 4 errors
        clear_stream(50);
        gen_hdb3(40);
        for (int j = 40; j < 44; j++) s[j] = ILL;
        run_stream();
        chk("lock_pre",  int'(o_lk[30]), 0);
        chk("lock_rise", int'(o_lk[31]), 1);
        chk("lock_hold", int'(o_lk[42]), 1);
        chk("lock_fall", int'(o_lk[43]), 0);

        // saturation, then clear coinciding with an error increment
        clear_stream(72);
        for (int j = 0; j < 72; j++) s[j] = ILL;
        clr_a[71] = 1'b1;
        run_stream();
        chk("sat_ecnt", o_ec[69], CMAX);
        chk("sat_scnt", o_sc[69], CMAX);
        chk("clr_ecnt", o_ec[71], 0);
        chk("clr_scnt", o_sc[71], 0);

        // random encoder streams with sparse corruption
        for (int it = 0; it < 16; it++) begin
            clear_stream(150);
            gen_hdb3(150);
            rate = (it % 2 == 1) ? 100 : 12;
            for (int j = 0; j < 150; j++) begin
                if ($urandom_range(0, rate - 1) == 0) begin
                    r = int'($urandom_range(0, 3));
                    s[j] = (r == 0) ? 0 : (r == 1) ? 1 :
                           (r == 2) ? -1 : ILL;
                end
                clr_a[j] = ($urandom_range(0, 49) == 0);
            end
            run_stream();
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
